// File: rtl/sqrt_21b.sv
// sqrt_21b: fully pipelined restoring square root of a 21-bit unsigned operand.
// The operand is padded to 22 bits (11 bit pairs). Stage k consumes one pair,
// MSB first, and resolves one root bit. The restoring step never leaves a
// negative partial remainder, so the final remainder needs no correction.
// Timing: operand registered at edge N, stages 1..10 at edges N+1..N+10,
// the last step lands in the output registers at edge N+11.
module sqrt_21b (
   input  logic        clk_main,
   input  logic        sys_rst,
   input  logic        in_valid,
   input  logic [20:0] radical,
   output logic        out_valid,
   output logic [10:0] q,
   output logic [11:0] remainder
);

   localparam int NSTG = 11;

   // per-stage state: valid, partial root, partial remainder, unconsumed radical bits
   logic        v_q    [NSTG];
   logic [10:0] root_q [NSTG];
   logic [11:0] rem_q  [NSTG];
   logic [21:0] rad_q  [NSTG];

   // result of applying one root-bit step to each stage's registered state
   logic [10:0] root_d [NSTG];
   logic [11:0] rem_d  [NSTG];
   logic [13:0] rem_t  [NSTG];
   logic [13:0] trial  [NSTG];

   // one restoring step per stage: bring in the next bit pair, try subtracting 4r+1
   always_comb begin
      for (int i = 0; i < NSTG; i++) begin
         rem_t[i] = {rem_q[i], rad_q[i][21:20]};
         trial[i] = {1'b0, root_q[i], 2'b01};
         if (rem_t[i] >= trial[i]) begin
            rem_d[i]  = 12'(rem_t[i] - trial[i]);
            root_d[i] = {root_q[i][9:0], 1'b1};
         end else begin
            rem_d[i]  = rem_t[i][11:0];
            root_d[i] = {root_q[i][9:0], 1'b0};
         end
      end
   end

   // pipeline registers: stage 0 captures the operand, later stages take the previous step
   always_ff @(posedge clk_main or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < NSTG; i++) begin
            v_q[i]    <= 1'b0;
            root_q[i] <= '0;
            rem_q[i]  <= '0;
            rad_q[i]  <= '0;
         end
      end else begin
         v_q[0]    <= in_valid;
         root_q[0] <= '0;
         rem_q[0]  <= '0;
         rad_q[0]  <= {1'b0, radical};
         for (int i = 1; i < NSTG; i++) begin
            v_q[i]    <= v_q[i-1];
            root_q[i] <= root_d[i-1];
            rem_q[i]  <= rem_d[i-1];
            rad_q[i]  <= {rad_q[i-1][19:0], 2'b00};
         end
      end
   end

   // output registers: the final step is captured only for valid operands so results hold in gaps
   always_ff @(posedge clk_main or posedge sys_rst) begin
      if (sys_rst) begin
         out_valid <= 1'b0;
         q         <= '0;
         remainder <= '0;
      end else begin
         out_valid <= v_q[NSTG-1];
         if (v_q[NSTG-1]) begin
            q         <= root_d[NSTG-1];
            remainder <= rem_d[NSTG-1];
         end
      end
   end

endmodule

// File: tb/tb_sqrt_21b.sv
// tb_sqrt_21b: directed and random stimulus against a floor-sqrt reference
// with an in-order scoreboard keyed on acceptance cycle.
module tb_sqrt_21b;

   logic        clk_main = 1'b0;
   logic        sys_rst;
   logic        in_valid;
   logic [20:0] radical;
   logic        out_valid;
   logic [10:0] q;
   logic [11:0] remainder;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_q = 0;
   int last_r = 0;

   typedef struct {
      int cyc;
      int eq;
      int er;
   } exp_t;
   exp_t sb[$];

   sqrt_21b dut (
      .clk_main  (clk_main),
      .sys_rst   (sys_rst),
      .in_valid  (in_valid),
      .radical   (radical),
      .out_valid (out_valid),
      .q         (q),
      .remainder (remainder)
   );

   always #5 clk_main = ~clk_main;

   function automatic int isqrt(int x);
      int r;
      r = int'($sqrt(real'(x)));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   // one clock: record the accepted operand, then check outputs 1 time unit after the edge
   task automatic cycle(input bit use_const = 0, input int cq = 0, input int cr = 0);
      exp_t e;
      bit   exp_v;
      int   x;
      @(posedge clk_main);
      cyc++;
      if (in_valid && !sys_rst) begin
         x    = int'(radical);
         e.cyc = cyc;
         e.eq  = use_const ? cq : isqrt(x);
         e.er  = use_const ? cr : x - e.eq * e.eq;
         sb.push_back(e);
      end
      #1;
      exp_v = 1'b0;
      if (sb.size() > 0) begin
         checks++;
         assert (sb[0].cyc >= cyc - 11) else begin
            errors++;
            $error("FAIL latency: result for cycle %0d never appeared (now %0d)", sb[0].cyc, cyc);
         end
         if (sb[0].cyc < cyc - 11) void'(sb.pop_front());
         else if (sb[0].cyc == cyc - 11) begin
            exp_v  = 1'b1;
            last_q = sb[0].eq;
            last_r = sb[0].er;
            void'(sb.pop_front());
         end
      end
      checks++;
      assert (out_valid === exp_v) else begin
         errors++;
         $error("FAIL out_valid @%0d: got %b expected %b", cyc, out_valid, exp_v);
      end
      checks++;
      assert (q === 11'(last_q)) else begin
         errors++;
         $error("FAIL q @%0d: got %0d expected %0d", cyc, q, last_q);
      end
      checks++;
      assert (remainder === 12'(last_r)) else begin
         errors++;
         $error("FAIL remainder @%0d: got %0d expected %0d", cyc, remainder, last_r);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic feed_const(input int x, input int cq, input int cr);
      in_valid = 1'b1;
      radical  = 21'(x);
      cycle(1, cq, cr);
      in_valid = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      checks++;
      assert (out_valid === 1'b0 && q === 11'd0 && remainder === 12'd0) else begin
         errors++;
         $error("FAIL %s: got v=%b q=%0d r=%0d expected all zero", tag, out_valid, q, remainder);
      end
   endtask

   task automatic async_reset(input int hold);
      #3;
      sys_rst = 1'b1;
      #1;
      check_zero("async_reset");
      sb.delete();
      last_q = 0;
      last_r = 0;
      in_valid = 1'b0;
      for (int i = 0; i < hold; i++) cycle();
      sys_rst = 1'b0;
   endtask

   initial begin
      sys_rst  = 1'b1;
      in_valid = 1'b0;
      radical  = '0;
      #1;
      check_zero("reset_state");
      for (int i = 0; i < 3; i++) cycle();
      sys_rst = 1'b0;

      // small operands, one at a time
      feed_const(0, 0, 0); idle(12);
      feed_const(1, 1, 0); idle(12);
      feed_const(2, 1, 1); idle(12);
      feed_const(3, 1, 2); idle(12);
      feed_const(4, 2, 0); idle(12);

      // extremes
      feed_const(2097151, 1448, 447);
      feed_const(1048575, 1023, 2046);
      feed_const(1000000, 1000, 0);
      idle(14);

      // ramp, back to back
      in_valid = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         radical = 21'(i);
         cycle();
      end
      idle(14);

      // gapped pattern 1,0,0,1,1 with holds in the gaps
      feed_const(1000000, 1000, 0);
      idle(2);
      feed_const(2097151, 1448, 447);
      feed_const(12345, 111, 24);
      idle(14);

      // reset mid-flight: 3 operands, 5 cycles later reset
      feed_const(99999, 316, 143);
      feed_const(500000, 707, 151);
      feed_const(777, 27, 48);
      idle(5);
      async_reset(3);
      idle(20);

      // accepted on the first edge after release
      feed_const(144, 12, 0);
      idle(13);

      // random stream with random gaps
      for (int i = 0; i < 20000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 15))
            0:       radical = 21'h1FFFFF;
            1:       radical = 21'd0;
            default: radical = 21'($urandom);
         endcase
         cycle();
      end
      idle(15);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
